sc_input_conditioner: RTL and testbench
=======================================

Name: sc_input_conditioner

Overview:
- Upstream front end for the point-control state machine.
- Takes raw, bouncing, active-low board pushbuttons (start, left, right) and produces clean, synchronized, debounced active-low levels for the state machine's button inputs.
- Also generates the periodic active-low one-cycle move tick (T0) that drives automatic point movement.
- Sits between the board pins and the state machine, in the same clock domain.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required before a debounced output follows the raw input (20 ms at 50 MHz). Must be >= 2.
- TICK_PERIOD, 25000000: cycles between T0 pulses (0.5 s at 50 MHz). Must be >= 2.
- DEBOUNCE_W, $clog2(DEBOUNCE_CYCLES): debounce counter width (derived).
- TICK_W, $clog2(TICK_PERIOD): tick counter width (derived).

Ports:
- SC_INPUTCONDITIONER_CLOCK_50  input  1  system clock, 50 MHz.
- SC_INPUTCONDITIONER_RESET_InLow  input  1  reset, asynchronous, active-low.
- SC_INPUTCONDITIONER_startButtonRaw_InLow  input  1  raw start pushbutton, asynchronous, 0 = pressed.
- SC_INPUTCONDITIONER_leftButtonRaw_InLow  input  1  raw left pushbutton, asynchronous, 0 = pressed.
- SC_INPUTCONDITIONER_rightButtonRaw_InLow  input  1  raw right pushbutton, asynchronous, 0 = pressed.
- SC_INPUTCONDITIONER_startButton_OutLow  output  1  debounced start level, 0 = pressed.
- SC_INPUTCONDITIONER_leftButton_OutLow  output  1  debounced left level, 0 = pressed.
- SC_INPUTCONDITIONER_rightButton_OutLow  output  1  debounced right level, 0 = pressed.
- SC_INPUTCONDITIONER_T0_OutLow  output  1  move tick, low for exactly one cycle per period.

Behaviour:
- One clock. Reset is asynchronous and active-low. All flops are cleared asynchronously on reset low and resume on the first edge after release.
- Reset values:
  - All synchronizer flops = 1.
  - All debounced outputs = 1 (released).
  - T0_OutLow = 1.
  - All counters = 0.
  - Start-edge register = 1.
- All outputs are registered; no combinational path from input to output.
- Per button (identical, independent channels):
  - Two-flop synchronizer s1 -> s2.
  - A stable register drives the output.
  - Counter cnt.
  - If s2 == stable: cnt <= 0.
  - If s2 != stable and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - If s2 != stable and cnt == DEBOUNCE_CYCLES-1: stable <= s2 and cnt <= 0.
- Debounce latency: the output changes on clock edge number DEBOUNCE_CYCLES+2, counting the first edge that samples the new raw level as edge 1. This applies equally to press and release.
- Glitch or bounce: any return of s2 to the stable value before the count completes clears cnt. A pulse of raw width <= DEBOUNCE_CYCLES-1 cycles never changes the output.
- Multiple buttons may be pressed simultaneously. Each output reflects its own channel; no priority is applied here.
- Tick generator:
  - tcnt counts 0..TICK_PERIOD-1 and wraps.
  - In the cycle where tcnt == TICK_PERIOD-1, T0_OutLow <= 0 for the next cycle and tcnt <= 0.
  - Otherwise T0_OutLow <= 1.
  - Result: exactly one low cycle every TICK_PERIOD cycles. First T0 low appears TICK_PERIOD cycles after reset release.
- Restart:
  - A debounced start falling edge (stable start 1 -> 0, detected via a registered copy) forces tcnt <= 0 and T0_OutLow <= 1 on the next edge.
  - Restart has priority over a coincident tick: that tick is suppressed.
  - The next T0 low occurs TICK_PERIOD cycles after the restart.
  - A held start does not re-restart. Release has no effect on the tick.
- Ticks continue while left or right is held; arbitration is the state machine's job.
- Reset mid-debounce or mid-period: everything returns to reset values immediately. A pending transition is discarded. A button held through reset release re-debounces from scratch, and its output goes low DEBOUNCE_CYCLES+2 edges later.

Decomposition:
- Shared package sc_input_pkg: default constants DEFAULT_DEBOUNCE_CYCLES (1000000) and DEFAULT_TICK_PERIOD (25000000), plus a simulation-override pair (4, 10).
- One sub-module, sc_debounce: synchronizer, counter and stable register for a single bit, parameterized by DEBOUNCE_CYCLES. Instantiated three times.
- Tick generator and restart logic live in the top module.

Test Plan (DEBOUNCE_CYCLES=4, TICK_PERIOD=10):
- Reset held low for 3 cycles, then released -> all button outputs 1; T0 first low exactly 10 cycles after release; low again every 10 cycles, each low lasting 1 cycle.
- Raw left held 0 from edge 1 -> leftButton_OutLow goes 0 after edge 6. Raw released -> goes 1 six edges after release is first sampled.
- Raw right bounce 0,1,0,1,0 (1 cycle each), then steady 0 -> no output change during the bounce; output 0 six edges after the last steady 0 is sampled.
- Debounced start press arriving in the same cycle the tick would fire -> that T0 pulse is suppressed; next T0 low exactly 10 cycles after the restart; holding start for 50 cycles yields pulses every 10 cycles with no further restarts.
- Start, left and right pressed simultaneously -> all three outputs fall on the same edge (edge 6).
- Reset asserted while left has been held 2 cycles into its count (output still 1) -> outputs 1 immediately; after release with left still held -> left output 0 six edges later; tick period restarts from 0.

Source files
------------

// File: rtl/sc_input_pkg.sv
// Shared constants and types for the pushbutton input conditioner.
// The SIM_* pair shortens debounce and tick period so simulation stays fast.
package sc_input_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
  localparam int DEFAULT_TICK_PERIOD     = 25000000;

  localparam int SIM_DEBOUNCE_CYCLES = 4;
  localparam int SIM_TICK_PERIOD     = 10;

  // One bit per board button, all active-low.
  typedef struct packed {
    logic start;
    logic left;
    logic right;
  } button_t;

endpackage

// File: rtl/sc_input_conditioner_debounce.sv
// Single-bit conditioner: a two-flop synchronizer followed by a stable-level
// register that only follows the input after DEBOUNCE_CYCLES unchanged samples.
module sc_debounce
  import sc_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int DEBOUNCE_W      = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam logic [DEBOUNCE_W-1:0] CNT_MAX = DEBOUNCE_W'(DEBOUNCE_CYCLES - 1);

  logic                  s1;
  logic                  s2;
  logic [DEBOUNCE_W-1:0] cnt;

  // Any sample that agrees with the current level restarts the count,
  // so bounces shorter than the window never reach the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + DEBOUNCE_W'(1);
      end
    end
  end

endmodule

// File: rtl/sc_input_conditioner.sv
// Board front end: debounces start/left/right and generates the periodic
// active-low move tick, which a fresh start press realigns to zero.
module sc_input_conditioner
  import sc_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int TICK_PERIOD     = DEFAULT_TICK_PERIOD,
  parameter int DEBOUNCE_W      = $clog2(DEBOUNCE_CYCLES),
  parameter int TICK_W          = $clog2(TICK_PERIOD)
) (
  input  logic SC_INPUTCONDITIONER_CLOCK_50,
  input  logic SC_INPUTCONDITIONER_RESET_InLow,
  input  logic SC_INPUTCONDITIONER_startButtonRaw_InLow,
  input  logic SC_INPUTCONDITIONER_leftButtonRaw_InLow,
  input  logic SC_INPUTCONDITIONER_rightButtonRaw_InLow,
  output logic SC_INPUTCONDITIONER_startButton_OutLow,
  output logic SC_INPUTCONDITIONER_leftButton_OutLow,
  output logic SC_INPUTCONDITIONER_rightButton_OutLow,
  output logic SC_INPUTCONDITIONER_T0_OutLow
);

  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_PERIOD - 1);

  logic clk;
  logic rst_n;

  assign clk   = SC_INPUTCONDITIONER_CLOCK_50;
  assign rst_n = SC_INPUTCONDITIONER_RESET_InLow;

  button_t raw;
  button_t level;

  assign raw.start = SC_INPUTCONDITIONER_startButtonRaw_InLow;
  assign raw.left  = SC_INPUTCONDITIONER_leftButtonRaw_InLow;
  assign raw.right = SC_INPUTCONDITIONER_rightButtonRaw_InLow;

  sc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DEBOUNCE_W(DEBOUNCE_W)) u_start (
    .clk(clk), .rst_n(rst_n), .raw(raw.start), .level(level.start)
  );

  sc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DEBOUNCE_W(DEBOUNCE_W)) u_left (
    .clk(clk), .rst_n(rst_n), .raw(raw.left), .level(level.left)
  );

  sc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DEBOUNCE_W(DEBOUNCE_W)) u_right (
    .clk(clk), .rst_n(rst_n), .raw(raw.right), .level(level.right)
  );

  logic              start_prev;
  logic              restart;
  logic [TICK_W-1:0] tcnt;
  logic              t0;

  // Only the debounced 1->0 edge restarts; a held or released start does not.
  assign restart = start_prev & ~level.start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_prev <= 1'b1;
      tcnt       <= '0;
      t0         <= 1'b1;
    end else begin
      start_prev <= level.start;
      if (restart) begin
        tcnt <= '0;
        t0   <= 1'b1;
      end else if (tcnt == TICK_MAX) begin
        tcnt <= '0;
        t0   <= 1'b0;
      end else begin
        tcnt <= tcnt + TICK_W'(1);
        t0   <= 1'b1;
      end
    end
  end

  assign SC_INPUTCONDITIONER_startButton_OutLow = level.start;
  assign SC_INPUTCONDITIONER_leftButton_OutLow  = level.left;
  assign SC_INPUTCONDITIONER_rightButton_OutLow = level.right;
  assign SC_INPUTCONDITIONER_T0_OutLow          = t0;

endmodule

// File: tb/tb_sc_input_conditioner.sv
// Bench for sc_input_conditioner with the short simulation constants.
module tb_sc_input_conditioner;
  import sc_input_pkg::*;

  localparam int DB = SIM_DEBOUNCE_CYCLES;
  localparam int TP = SIM_TICK_PERIOD;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic raw_start, raw_left, raw_right;
  logic out_start, out_left, out_right, out_t0;

  always #5 clk = ~clk;

  sc_input_conditioner #(.DEBOUNCE_CYCLES(DB), .TICK_PERIOD(TP)) dut (
    .SC_INPUTCONDITIONER_CLOCK_50            (clk),
    .SC_INPUTCONDITIONER_RESET_InLow         (rst_n),
    .SC_INPUTCONDITIONER_startButtonRaw_InLow(raw_start),
    .SC_INPUTCONDITIONER_leftButtonRaw_InLow (raw_left),
    .SC_INPUTCONDITIONER_rightButtonRaw_InLow(raw_right),
    .SC_INPUTCONDITIONER_startButton_OutLow  (out_start),
    .SC_INPUTCONDITIONER_leftButton_OutLow   (out_left),
    .SC_INPUTCONDITIONER_rightButton_OutLow  (out_right),
    .SC_INPUTCONDITIONER_T0_OutLow           (out_t0)
  );

  // ---------------- scoreboard state ----------------
  // Each entry is {start, left, right, t0} expected after one clock edge.
  logic [3:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  // Expected-behaviour bookkeeping: raw sample history (bit 0 newest),
  // expected levels, edge number since reset release and next tick edge.
  logic [DB+1:0] h_start, h_left, h_right;
  logic          m_start, m_left, m_right, m_t0;
  logic          restart_pend;
  int            e_cnt;
  int            next_tick;

  // A level follows the raw value once DB consecutive samples, seen through
  // the two-edge synchronizer delay, all differ from the current level.
  function automatic logic settle(input logic [DB+1:0] h, input logic cur);
    logic v;
    logic same;
    v    = h[2];
    same = 1'b1;
    for (int i = 2; i <= DB + 1; i++)
      if (h[i] != v) same = 1'b0;
    return (same && (v != cur)) ? v : cur;
  endfunction

  task automatic model_reset();
    h_start      = '1;
    h_left       = '1;
    h_right      = '1;
    m_start      = 1'b1;
    m_left       = 1'b1;
    m_right      = 1'b1;
    m_t0         = 1'b1;
    restart_pend = 1'b0;
    e_cnt        = 0;
    next_tick    = TP;
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (edge %0d, time %0t)", name, act, exp, e_cnt, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock edge: advance the expectation, queue it, then leave 1 time
  // unit so callers change inputs well away from the sampling edge.
  task automatic step();
    logic prev_start;
    @(posedge clk);
    if (rst_n) begin
      e_cnt++;
      if (restart_pend) begin
        m_t0      = 1'b1;
        next_tick = e_cnt + TP;
      end else if (e_cnt == next_tick) begin
        m_t0      = 1'b0;
        next_tick = e_cnt + TP;
      end else begin
        m_t0 = 1'b1;
      end
      h_start    = {h_start[DB:0], raw_start};
      h_left     = {h_left[DB:0], raw_left};
      h_right    = {h_right[DB:0], raw_right};
      prev_start = m_start;
      m_start    = settle(h_start, m_start);
      m_left     = settle(h_left, m_left);
      m_right    = settle(h_right, m_right);
      restart_pend = prev_start && !m_start;
    end else begin
      model_reset();
    end
    exp_q.push_back({m_start, m_left, m_right, m_t0});
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic set_raw(input logic s, input logic l, input logic r);
    raw_start = s;
    raw_left  = l;
    raw_right = r;
  endtask

  // Reset lands mid-cycle, after that cycle's output check; the outputs
  // must already be at their reset values before any further clock edge.
  task automatic async_reset(input int hold);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_reset_start", out_start, 1'b1);
    check("async_reset_left",  out_left,  1'b1);
    check("async_reset_right", out_right, 1'b1);
    check("async_reset_t0",    out_t0,    1'b1);
    steps(hold);
    rst_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [3:0] e;
      e = exp_q.pop_front();
      check("start_out", out_start, e[3]);
      check("left_out",  out_left,  e[2]);
      check("right_out", out_right, e[1]);
      check("t0_out",    out_t0,    e[0]);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached with %0d expectations pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    rst_n = 1'b0;
    set_raw(1'b1, 1'b1, 1'b1);
    model_reset();

    // Reset for 3 cycles, then idle: ticks at edges 10, 20, 30.
    steps(3);
    rst_n = 1'b1;
    steps(35);

    // Left press held, then released.
    set_raw(1'b1, 1'b0, 1'b1);
    steps(12);
    set_raw(1'b1, 1'b1, 1'b1);
    steps(10);

    // Right bounce 0,1,0,1,0 then steady low, then release.
    set_raw(1'b1, 1'b1, 1'b0); step();
    set_raw(1'b1, 1'b1, 1'b1); step();
    set_raw(1'b1, 1'b1, 1'b0); step();
    set_raw(1'b1, 1'b1, 1'b1); step();
    set_raw(1'b1, 1'b1, 1'b0);
    steps(12);
    set_raw(1'b1, 1'b1, 1'b1);
    steps(10);

    // Time a start press so its restart lands on the edge a tick would fire.
    guard = 0;
    while ((e_cnt + 1 != next_tick - (DB + 2)) && (guard < 3 * TP)) begin
      step();
      guard++;
    end
    set_raw(1'b0, 1'b1, 1'b1);
    steps(50);
    set_raw(1'b1, 1'b1, 1'b1);
    steps(12);

    // All three pressed together.
    set_raw(1'b0, 1'b0, 1'b0);
    steps(10);
    set_raw(1'b1, 1'b1, 1'b1);
    steps(10);

    // Reset part-way through a left debounce; left kept held through release.
    set_raw(1'b1, 1'b0, 1'b1);
    steps(3);
    async_reset(2);
    steps(15);
    set_raw(1'b1, 1'b1, 1'b1);
    steps(12);

    // ---------------- final report ----------------
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
